// File: rtl/pulse_request_arbiter_pkg.sv
// Shared types and helpers for the pulse request arbiter: FSM state encoding
// and the modular index used by the round-robin scan and pointer update.
package pulse_request_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/pulse_request_arbiter_if.sv
// Request/command bundle between the button front end, the arbiter and the
// downstream single-user command unit.
interface pulse_request_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] long_pulse;
    logic         done;
    logic         start;
    logic [N-1:0] grant;
    logic [N-1:0] pending;
    logic         busy;

    modport master (
        output long_pulse, done,
        input  start, grant, pending, busy
    );

    modport slave (
        input  long_pulse, done,
        output start, grant, pending, busy
    );
endinterface

// File: rtl/pulse_request_arbiter_edge_pulser.sv
// Reduces one raw request level to a single-cycle pulse on its rising edge.
// Reset reloads the history so a level held through reset never fires.
module pulse_request_arbiter_edge_pulser (
    input  logic clk,
    input  logic rst,
    input  logic long_pulse_i,
    output logic single_pulse_o
);

    logic prev_q;

    // History tracks the level every cycle, including while in reset
    always_ff @(posedge clk) begin
        prev_q <= long_pulse_i;
    end

    assign single_pulse_o = long_pulse_i & ~prev_q & ~rst;

endmodule

// File: rtl/pulse_request_arbiter.sv
// Latches edge-reduced button requests as pending and serves them round-robin
// to one downstream command unit through a start/done handshake.
module pulse_request_arbiter
    import pulse_request_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_request_arbiter_if.slave  bus
);

    logic [N-1:0]     edge_s;
    logic [N-1:0]     onehot_s;
    logic [N-1:0]     clr_s;
    logic [N-1:0]     pending_d;
    logic             found_s;
    logic [PTR_W-1:0] pick_s;

    state_e           state_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     grant_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_q;

    for (genvar g = 0; g < N; g++) begin : g_line
        pulse_request_arbiter_edge_pulser u_pulser (
            .clk            (clk),
            .rst            (rst),
            .long_pulse_i   (bus.long_pulse[g]),
            .single_pulse_o (edge_s[g])
        );
    end

    // Rotated scan: first pending line at or after the pointer wins
    always_comb begin
        found_s = 1'b0;
        pick_s  = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!found_s && pending_q[PTR_W'(rr_index(32'(ptr_q), 32'(k), 32'(N)))]) begin
                found_s = 1'b1;
                pick_s  = PTR_W'(rr_index(32'(ptr_q), 32'(k), 32'(N)));
            end else begin
                found_s = found_s;
            end
        end
    end

    assign onehot_s = {{(N-1){1'b0}}, 1'b1} << pick_s;

    // Winner's bit is cleared, but a new edge on the same cycle re-sets it
    always_comb begin
        clr_s = '0;
        if (state_q == S_IDLE && found_s) begin
            clr_s = onehot_s;
        end else begin
            clr_s = '0;
        end
        pending_d = (pending_q & ~clr_s) | edge_s;
    end

    // Arbitration FSM with pending, grant and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                S_IDLE: begin
                    if (found_s) begin
                        grant_q <= onehot_s;
                        win_q   <= pick_s;
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.done) begin
                        grant_q <= '0;
                        ptr_q   <= PTR_W'(rr_index(32'(win_q), 32'd1, 32'(N)));
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start   = (state_q == S_ISSUE);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.grant   = grant_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_pulse_request_arbiter.sv
// Scoreboard bench for pulse_request_arbiter: directed scenarios followed by
// random button/done traffic, all checked against a behavioural model.
module tb_pulse_request_arbiter;

    localparam int N = 4;
    localparam int PH_FREE   = 0;
    localparam int PH_ISSUED = 1;
    localparam int PH_HOLD   = 2;

    logic clk = 1'b0;
    logic rst;

    pulse_request_arbiter_if #(.N(N)) bus ();

    pulse_request_arbiter #(.N(N), .PTR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] pend;
        logic [N-1:0] gnt;
        logic         st;
        logic         bsy;
    } exp_t;

    exp_t         stat_q[$];
    logic [N-1:0] gnt_sb[$];
    logic [N-1:0] obs_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit m_pend[N];
    bit m_prev[N];
    int m_owner = -1;
    int m_ptr   = 0;
    int m_phase = PH_FREE;
    bit m_start = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: requests are remembered per line, served in circular order from ptr
    task automatic model_step();
        bit           rises[N];
        exp_t         e;
        logic [N-1:0] oh;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = bus.long_pulse[i];
                m_pend[i] = 1'b0;
            end
            m_owner = -1;
            m_ptr   = 0;
            m_phase = PH_FREE;
        end else begin
            for (int i = 0; i < N; i++) begin
                rises[i]  = bus.long_pulse[i] && !m_prev[i];
                m_prev[i] = bus.long_pulse[i];
            end
            if (m_phase == PH_FREE) begin
                for (int k = 0; k < N; k++) begin
                    int c = (m_ptr + k) % N;
                    if (m_owner < 0 && m_pend[c]) m_owner = c;
                end
                if (m_owner >= 0) begin
                    m_pend[m_owner] = 1'b0;
                    m_phase = PH_ISSUED;
                    oh = '0;
                    oh[m_owner] = 1'b1;
                    gnt_sb.push_back(oh);
                end
            end else if (m_phase == PH_ISSUED) begin
                m_phase = PH_HOLD;
            end else if (bus.done) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_phase = PH_FREE;
            end
            for (int i = 0; i < N; i++) if (rises[i]) m_pend[i] = 1'b1;
        end
        for (int i = 0; i < N; i++) e.pend[i] = m_pend[i];
        e.gnt = '0;
        if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
        e.st  = (m_phase == PH_ISSUED);
        e.bsy = (m_phase != PH_FREE);
        m_start = e.st;
        stat_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare every cycle's outputs, and each start against the grant scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                e = stat_q.pop_front();
                check("pending", 32'(bus.pending), 32'(e.pend));
                check("grant",   32'(bus.grant),   32'(e.gnt));
                check("start",   32'(bus.start),   32'(e.st));
                check("busy",    32'(bus.busy),    32'(e.bsy));
            end
            if (bus.start === 1'b1) begin
                obs_log.push_back(bus.grant);
                if (gnt_sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: got grant 0x%0h, want no start at %0t", bus.grant, $time);
                end else begin
                    check("grant_at_start", 32'(bus.grant), 32'(gnt_sb.pop_front()));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (m_start) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_start: got no start, want start within %0d cycles at %0t", max_cycles, $time);
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.long_pulse = 4'b0001;
        bus.done       = 1'b0;
        cyc(3);

        // Level held through reset must not request
        rst = 1'b0;
        cyc(20);
        check("t1_no_pending", 32'(bus.pending), 32'd0);
        bus.long_pulse = 4'b0000;
        cyc(2);

        // Single press held long: one service only
        bus.long_pulse = 4'b0100;
        wait_start(10);
        check("t2_grant", 32'(bus.grant), 32'h4);
        cyc(5);
        pulse_done();
        check("t2_grant_released", 32'(bus.grant), 32'd0);
        cyc(45);
        bus.long_pulse = 4'b0000;
        cyc(2);

        // Three simultaneous requests from ptr=0
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        obs_log.delete();
        bus.long_pulse = 4'b1011;
        for (int r = 0; r < 3; r++) begin
            wait_start(20);
            cyc(3);
            pulse_done();
        end
        check("t3_log_size", 32'(obs_log.size()), 32'd3);
        if (obs_log.size() >= 3) begin
            check("t3_order0", 32'(obs_log[0]), 32'h1);
            check("t3_order1", 32'(obs_log[1]), 32'h2);
            check("t3_order2", 32'(obs_log[2]), 32'h8);
        end
        bus.long_pulse = 4'b0000;
        cyc(3);

        // Re-press of the granted line is served again
        obs_log.delete();
        bus.long_pulse = 4'b0010;
        wait_start(10);
        bus.long_pulse = 4'b0000;
        cyc(1);
        bus.long_pulse = 4'b0010;
        cyc(2);
        check("t4_repend", 32'(bus.pending), 32'h2);
        pulse_done();
        wait_start(10);
        check("t4_log_size", 32'(obs_log.size()), 32'd2);
        if (obs_log.size() >= 2) check("t4_second", 32'(obs_log[1]), 32'h2);
        cyc(1);
        pulse_done();
        bus.long_pulse = 4'b0000;
        cyc(3);

        // done in IDLE and in ISSUE is ignored
        pulse_done();
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        bus.long_pulse = 4'b1000;
        wait_start(10);
        pulse_done();
        check("t5_issue_grant", 32'(bus.grant), 32'h8);
        cyc(2);
        check("t5_hold_grant", 32'(bus.grant), 32'h8);
        check("t5_hold_busy", 32'(bus.busy), 32'd1);
        pulse_done();
        bus.long_pulse = 4'b0000;
        cyc(2);

        // Reset while waiting with other requests pending
        bus.long_pulse = 4'b0001;
        wait_start(10);
        cyc(1);
        bus.long_pulse = 4'b1011;
        cyc(2);
        check("t6_pending", 32'(bus.pending), 32'hA);
        rst = 1'b1;
        cyc(1);
        check("t6_rst_out", 32'({bus.pending, bus.grant, bus.start, bus.busy}), 32'd0);
        rst = 1'b0;
        cyc(3);
        check("t6_after_pending", 32'(bus.pending), 32'd0);
        bus.long_pulse = 4'b0000;
        cyc(2);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) bus.long_pulse[i] = ~bus.long_pulse[i];
            end
            bus.done = ($urandom_range(0, 3) == 0);
        end
        rst            = 1'b0;
        bus.done       = 1'b0;
        bus.long_pulse = 4'b0000;
        cyc(3);
        check("sb_drained", 32'(gnt_sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
